systolic_feeder: RTL and testbench

Front-end stage of the int8 systolic matrix unit. Reads one activation row-vector (A) and one weight row-vector (B) per cycle from the operand buffers, adds the signed input offset to activations, skews both streams diagonally and drives the left and top edges of the N×N PE array. It also generates the per-row accumulator-clear strobe and reports tile completion once the bottom-right PE holds its final sum.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/skew_line.sv | 33 +++
 rtl/systolic_feeder.sv | 177 +++++++++++++++++
 tb/tb_systolic_feeder.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic matrix unit front end: array geometry,
// operand/accumulator widths and the feeder FSM state encoding.
package systolic_pkg;
  localparam int N     = 4;
  localparam int AW    = 8;
  localparam int KW    = 8;
  localparam int ACT_W = 9;
  localparam int WGT_W = 8;
  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN
  } state_e;
endpackage

// File: rtl/skew_line.sv
// Fixed-depth delay chain with synchronous active-low clear; DEPTH=0 is a
// plain wire so lane 0 of the skew needs no special casing in the parent.
module skew_line #(
  parameter int DEPTH = 1,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = clk ^ rst_n;
    assign dout       = din;
  end else begin : g_chain
    logic [W-1:0] stage [DEPTH];

    // NOTE: the whole chain is cleared on reset (not just a valid bit) so a
    // tile aborted mid-flight cannot leak stale lanes onto the array edges.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
      end else begin
        // NOTE: non-blocking assignment makes every stage shift on the same edge.
        stage[0] <= din;
        for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
      end
    end

    assign dout = stage[DEPTH-1];
  end
endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for the NxN systolic array: reads A/B rows, offsets and skews
// them onto the array edges. Optional activation offset: FEEDER_OFFSET_EN.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N  = systolic_pkg::N,
  parameter int AW = systolic_pkg::AW,
  parameter int KW = systolic_pkg::KW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [KW-1:0]           k_len,
  input  logic [AW-1:0]           a_base,
  input  logic [AW-1:0]           b_base,
  input  logic signed [ACT_W-1:0] input_offset,
  output logic                    busy,
  output logic                    done,
  output logic                    a_ren,
  output logic                    b_ren,
  output logic [AW-1:0]           a_addr,
  output logic [AW-1:0]           b_addr,
  input  logic [N*WGT_W-1:0]      a_rdata,
  input  logic [N*WGT_W-1:0]      b_rdata,
  output logic [N*ACT_W-1:0]      left_out,
  output logic [N*WGT_W-1:0]      top_out,
  output logic [N-1:0]            pe_rst_out
);
  // Drain lasts until the bottom-right PE has registered its last product.
  localparam logic [KW-1:0] DRAIN_LAST = KW'(2 * N + 1);
  localparam int            EXT_W      = ACT_W - WGT_W;

  state_e        state, state_nx;
  logic [KW-1:0] cnt, cnt_nx;
  logic [KW-1:0] k_len_q;
  logic [AW-1:0] a_base_q, b_base_q;
  logic          rd_valid, rd_first;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      k_len_q  <= '0;
      a_base_q <= '0;
      b_base_q <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == ST_IDLE && start) begin
        k_len_q  <= k_len;
        a_base_q <= a_base;
        b_base_q <= b_base;
      end
    end
  end

  always_comb begin
    // NOTE: every output of this block has a default first, so no path infers a latch.
    state_nx = state;
    cnt_nx   = cnt;
    busy     = 1'b0;
    done     = 1'b0;
    a_ren    = 1'b0;
    b_ren    = 1'b0;
    a_addr   = '0;
    b_addr   = '0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          // An empty tile skips straight to the final drain cycle.
          if (k_len == '0) begin
            state_nx = ST_DRAIN;
            cnt_nx   = DRAIN_LAST;
          end else begin
            state_nx = ST_FEED;
            cnt_nx   = '0;
          end
        end
      end
      ST_FEED: begin
        busy   = 1'b1;
        a_ren  = 1'b1;
        b_ren  = 1'b1;
        a_addr = a_base_q + AW'(cnt);
        b_addr = b_base_q + AW'(cnt);
        if (cnt == k_len_q - KW'(1)) begin
          state_nx = ST_DRAIN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + KW'(1);
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (cnt == DRAIN_LAST) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + KW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Read data returns one cycle after the enable; the first beat is k=0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_first <= 1'b0;
    end else begin
      rd_valid <= a_ren;
      rd_first <= a_ren && (cnt == '0);
    end
  end

`ifdef FEEDER_OFFSET_EN
  logic [ACT_W-1:0] offset_q;

  always_ff @(posedge clk) begin
    if (!rst_n)                        offset_q <= '0;
    else if (state == ST_IDLE && start) offset_q <= input_offset;
  end
`else
  logic unused_offset;
  assign unused_offset = ^input_offset;
`endif

  logic [ACT_W:0]   row_in  [N];
  logic [ACT_W:0]   row_dly [N];
  logic [WGT_W-1:0] col_in  [N];
  logic [WGT_W-1:0] col_dly [N];

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic [WGT_W-1:0] a_lane;
    logic [ACT_W-1:0] act;

    assign a_lane = a_rdata[i*WGT_W +: WGT_W];
`ifdef FEEDER_OFFSET_EN
    assign act = {{EXT_W{a_lane[WGT_W-1]}}, a_lane} + offset_q;
`else
    assign act = {{EXT_W{a_lane[WGT_W-1]}}, a_lane};
`endif
    // Lanes are forced to zero outside the read window; the clear flag rides with row data.
    assign row_in[i] = rd_valid ? {rd_first, act} : '0;
    assign col_in[i] = rd_valid ? b_rdata[i*WGT_W +: WGT_W] : '0;

    skew_line #(.DEPTH(i), .W(ACT_W + 1)) u_row_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (row_in[i]),
      .dout (row_dly[i])
    );

    skew_line #(.DEPTH(i), .W(WGT_W)) u_col_skew (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (col_in[i]),
      .dout (col_dly[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      left_out   <= '0;
      top_out    <= '0;
      pe_rst_out <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        left_out[i*ACT_W +: ACT_W] <= row_dly[i][ACT_W-1:0];
        top_out[i*WGT_W +: WGT_W]  <= col_dly[i];
        pe_rst_out[i]              <= row_dly[i][ACT_W];
      end
    end
  end
endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench for systolic_feeder: per-cycle comparison against a
// tile-level timing model, a PE-array model checked against a plain matmul.
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int AW = 8;
  localparam int KW = 8;
  localparam int DW = N * 8;
  localparam int MD = 1 << AW;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  start;
  logic [KW-1:0]         k_len;
  logic [AW-1:0]         a_base, b_base;
  logic signed [8:0]     input_offset;
  logic                  busy, done, a_ren, b_ren;
  logic [AW-1:0]         a_addr, b_addr;
  logic [DW-1:0]         a_rdata, b_rdata;
  logic [N*9-1:0]        left_out;
  logic [N*8-1:0]        top_out;
  logic [N-1:0]          pe_rst_out;

  systolic_feeder #(.N(N), .AW(AW), .KW(KW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .k_len       (k_len),
    .a_base      (a_base),
    .b_base      (b_base),
    .input_offset(input_offset),
    .busy        (busy),
    .done        (done),
    .a_ren       (a_ren),
    .b_ren       (b_ren),
    .a_addr      (a_addr),
    .b_addr      (b_addr),
    .a_rdata     (a_rdata),
    .b_rdata     (b_rdata),
    .left_out    (left_out),
    .top_out     (top_out),
    .pe_rst_out  (pe_rst_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Operand buffers: 1-cycle read latency, garbage when not read.
  logic [DW-1:0] mem_a [MD];
  logic [DW-1:0] mem_b [MD];
  always @(posedge clk) begin
    a_rdata <= a_ren ? mem_a[a_addr] : DW'($urandom);
    b_rdata <= b_ren ? mem_b[b_addr] : DW'($urandom);
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  function automatic int signed act_of(input logic [7:0] a, input logic signed [8:0] off);
    logic signed [8:0] v;
    v = {a[7], a};
`ifdef FEEDER_OFFSET_EN
    v = v + off;
`else
    v = v + (off & 9'sd0);
`endif
    return int'(v);
  endfunction

  function automatic int done_rel_of(input int k);
    return (k == 0) ? 1 : k + 2 * N + 2;
  endfunction

  // Tile-level model: one tile at a time, described by its start cycle and parameters.
  bit                tile_on = 1'b0;
  int                t0 = 0;
  int                tk = 0;
  logic [AW-1:0]     tab = '0, tbb = '0;
  logic signed [8:0] toff = '0;

  function automatic bit model_idle();
    return !tile_on || (cyc > t0 + done_rel_of(tk));
  endfunction

  // PE array model fed from the DUT edges.
  int pa [N][N];
  int pb [N][N];
  bit pr [N][N];
  int acc [N][N];

  initial begin
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        pa[i][j] = 0; pb[i][j] = 0; pr[i][j] = 1'b0; acc[i][j] = 0;
      end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      int            rel, drel, k;
      bit            e_busy, e_done, e_ren;
      logic [AW-1:0] e_aa, e_ba, ad;
      logic [N*9-1:0] e_left;
      logic [N*8-1:0] e_top;
      logic [N-1:0]   e_pr;
      int na [N][N];
      int nb [N][N];
      bit nr [N][N];

      rel    = cyc - t0;
      drel   = done_rel_of(tk);
      e_busy = tile_on && rel >= 1 && rel <= drel;
      e_done = tile_on && rel == drel;
      e_ren  = tile_on && tk > 0 && rel >= 1 && rel <= tk;
      e_aa   = AW'(int'(tab) + rel - 1);
      e_ba   = AW'(int'(tbb) + rel - 1);
      e_left = '0;
      e_top  = '0;
      e_pr   = '0;
      for (int i = 0; i < N; i++) begin
        k = rel - 3 - i;
        if (tile_on && k >= 0 && k < tk) begin
          ad = AW'(int'(tab) + k);
          e_left[9*i +: 9] = 9'(act_of(mem_a[ad][8*i +: 8], toff));
          e_pr[i]          = (k == 0);
          ad = AW'(int'(tbb) + k);
          e_top[8*i +: 8]  = mem_b[ad][8*i +: 8];
        end
      end

      check("busy", 64'(busy), 64'(e_busy));
      check("done", 64'(done), 64'(e_done));
      check("a_ren", 64'(a_ren), 64'(e_ren));
      check("b_ren", 64'(b_ren), 64'(e_ren));
      if (e_ren) begin
        check("a_addr", 64'(a_addr), 64'(e_aa));
        check("b_addr", 64'(b_addr), 64'(e_ba));
      end
      check("left_out", 64'(left_out), 64'(e_left));
      check("top_out", 64'(top_out), 64'(e_top));
      check("pe_rst_out", 64'(pe_rst_out), 64'(e_pr));

      // Final array contents against a plain matrix product.
      if (e_done && tk > 0) begin
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++) begin
            int ref_c;
            ref_c = 0;
            for (int kk = 0; kk < tk; kk++)
              ref_c += act_of(mem_a[AW'(int'(tab) + kk)][8*i +: 8], toff) *
                       int'($signed(mem_b[AW'(int'(tbb) + kk)][8*j +: 8]));
            check($sformatf("pe_acc[%0d][%0d]", i, j), 64'(acc[i][j]), 64'(ref_c));
          end
      end

      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          na[i][j] = (j == 0) ? int'($signed(left_out[9*i +: 9])) : pa[i][j-1];
          nr[i][j] = (j == 0) ? pe_rst_out[i] : pr[i][j-1];
          nb[i][j] = (i == 0) ? int'($signed(top_out[8*j +: 8])) : pb[i-1][j];
        end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          acc[i][j] = nr[i][j] ? na[i][j] * nb[i][j] : acc[i][j] + na[i][j] * nb[i][j];
          pa[i][j]  = na[i][j];
          pb[i][j]  = nb[i][j];
          pr[i][j]  = nr[i][j];
        end

      // Decide whether this cycle's start is accepted.
      if (!rst_n) tile_on = 1'b0;
      else if (start && (!tile_on || cyc > t0 + drel)) begin
        tile_on = 1'b1;
        t0      = cyc;
        tk      = int'(k_len);
        tab     = a_base;
        tbb     = b_base;
        toff    = input_offset;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) tick();
  endtask

  task automatic at_cycle(input int n);
    do @(negedge clk); while (cyc < n);
  endtask

  task automatic launch(input int k, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                        input logic signed [8:0] off, output int c0);
    start        = 1'b1;
    k_len        = KW'(k);
    a_base       = ab;
    b_base       = bb;
    input_offset = off;
    c0           = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!model_idle() && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int c0;
    logic [8:0] exp_l [N];

    for (int a = 0; a < MD; a++) begin
      mem_a[a] = DW'($urandom);
      mem_b[a] = DW'($urandom);
    end

    // Reset held with start asserted: nothing may move.
    rst_n = 1'b0; start = 1'b1; k_len = 8'd5; a_base = 8'h11; b_base = 8'h22;
    input_offset = 9'sd3;
    tick(); tick(); tick();
    at_cycle(cyc);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ren", 64'({a_ren, b_ren}), 64'd0);
    check("rst_left", 64'(left_out), 64'd0);
    tick();
    rst_n = 1'b1; start = 1'b0;
    tick(); tick();

    // K=1 tile with boundary activations.
    mem_a[8'h10] = 32'h7F05_0080;
    mem_b[8'h20] = 32'h0403_0201;
`ifdef FEEDER_OFFSET_EN
    exp_l[0] = 9'd0;   exp_l[1] = 9'd128; exp_l[2] = 9'd133; exp_l[3] = 9'd255;
`else
    exp_l[0] = 9'h180; exp_l[1] = 9'd0;   exp_l[2] = 9'd5;   exp_l[3] = 9'd127;
`endif
    launch(1, 8'h10, 8'h20, 9'sd128, c0);
    for (int r = 3; r < 3 + N; r++) begin
      at_cycle(c0 + r);
      check($sformatf("k1_left%0d", r - 3), 64'(left_out[9*(r-3) +: 9]), 64'(exp_l[r-3]));
      check($sformatf("k1_top%0d", r - 3), 64'(top_out[8*(r-3) +: 8]), 64'(r - 2));
      check($sformatf("k1_perst%0d", r - 3), 64'(pe_rst_out), 64'(1 << (r - 3)));
    end
    at_cycle(c0 + 11);
    check("k1_done", 64'(done), 64'd1);
    tick();
    wait_idle();

    // K=8 with address wrap.
    launch(8, 8'hFC, 8'h40, 9'sd0, c0);
    at_cycle(c0 + 1);
    check("wrap_addr0", 64'(a_addr), 64'h0FC);
    at_cycle(c0 + 5);
    check("wrap_addr4", 64'(a_addr), 64'h000);
    at_cycle(c0 + 8);
    check("wrap_addr7", 64'(a_addr), 64'h003);
    at_cycle(c0 + 18);
    check("k8_done", 64'(done), 64'd1);
    tick();
    wait_idle();

    // Starts while busy are ignored, start right after done is taken.
    launch(8, 8'h30, 8'h50, -9'sd7, c0);
    goto(c0 + 5);
    start = 1'b1; k_len = 8'd3; a_base = 8'h90;
    tick();
    start = 1'b0;
    goto(c0 + 18);
    start = 1'b1; k_len = 8'd2; a_base = 8'hA0;
    at_cycle(c0 + 18);
    check("ign_done", 64'(done), 64'd1);
    tick();
    k_len = 8'd4; a_base = 8'h70; b_base = 8'h80; input_offset = 9'sd5;
    at_cycle(c0 + 19);
    check("ign_idle", 64'(busy), 64'd0);
    tick();
    start = 1'b0;
    at_cycle(c0 + 22);
    check("restart_perst0", 64'(pe_rst_out[0]), 64'd1);
    tick();
    wait_idle();

    // Empty tile.
    launch(0, 8'h00, 8'h00, 9'sd0, c0);
    at_cycle(c0 + 1);
    check("k0_busy", 64'(busy), 64'd1);
    check("k0_done", 64'(done), 64'd1);
    check("k0_ren", 64'(a_ren), 64'd0);
    at_cycle(c0 + 2);
    check("k0_busy_after", 64'(busy), 64'd0);
    tick();

    // Reset mid-tile, then a normal tile.
    launch(8, 8'h05, 8'h06, 9'sd1, c0);
    goto(c0 + 6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    at_cycle(c0 + 7);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_left", 64'(left_out), 64'd0);
    check("mid_rst_ren", 64'(a_ren), 64'd0);
    tick(); tick(); tick();
    launch(3, 8'h07, 8'h08, 9'sd2, c0);
    wait_idle();

    // Randomized tiles with stray starts and occasional resets.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0)
        for (int a = 0; a < MD; a++) begin
          mem_a[a] = DW'($urandom);
          mem_b[a] = DW'($urandom);
        end
      repeat ($urandom_range(0, 3)) tick();
      launch($urandom_range(0, 20), AW'($urandom), AW'($urandom),
             9'($signed($urandom_range(0, 64)) - 32), c0);
      while (!model_idle() && cyc < c0 + 200) begin
        start        = ($urandom_range(0, 7) == 0);
        k_len        = KW'($urandom_range(0, 12));
        a_base       = AW'($urandom);
        b_base       = AW'($urandom);
        input_offset = 9'($signed($urandom_range(0, 64)) - 32);
        rst_n        = ($urandom_range(0, 149) != 0);
        tick();
      end
      start = 1'b0;
      rst_n = 1'b1;
      tick();
      wait_idle();
    end

    repeat (4) tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
